// File: rtl/cnn_mem_responder.sv
// Dual-port SRAM responder for the KMEM/WMEM interface; clears itself after reset, then serves two ports.
// Reads return data 1 cycle after the access; no backpressure, accesses are ignored while mem_ready=0.
module cnn_mem_responder #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ADD1,
  input  logic              CSB1,
  input  logic              WEB1,
  input  logic              OEB1,
  input  logic [DATA_W-1:0] DATA_I1,
  output logic [DATA_W-1:0] DATA_O1,
  input  logic [ADDR_W-1:0] ADD2,
  input  logic              CSB2,
  input  logic              WEB2,
  input  logic              OEB2,
  input  logic [DATA_W-1:0] DATA_I2,
  output logic [DATA_W-1:0] DATA_O2,
  output logic              mem_ready,
  output logic              wr_coll
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  logic wr1, wr2, rd1, rd2;

  assign wr1 = ~CSB1 & ~WEB1;
  assign rd1 = ~CSB1 &  WEB1;
  assign wr2 = ~CSB2 & ~WEB2;
  assign rd2 = ~CSB2 &  WEB2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      rdata1    <= '0;
      rdata2    <= '0;
      mem_ready <= 1'b0;
      wr_coll   <= 1'b0;
    end else begin
      wr_coll <= 1'b0;
      case (state)
        CLEAR: begin
          mem[clr_cnt] <= INIT_VAL;
          clr_cnt      <= clr_cnt + 1'b1;
          rdata1       <= '0;
          rdata2       <= '0;
          if (clr_cnt == LAST) begin
            state     <= READY;
            mem_ready <= 1'b1;
          end
        end
        READY: begin
          // Reads sample the array before this edge's writes land, so a
          // cross-port read of a word being written returns the old value.
          if (rd1) rdata1 <= mem[ADD1];
          if (rd2) rdata2 <= mem[ADD2];
          // Port 1 is written last so it wins a same-address collision.
          if (wr2) mem[ADD2] <= DATA_I2;
          if (wr1) mem[ADD1] <= DATA_I1;
          wr_coll <= wr1 & wr2 & (ADD1 == ADD2);
        end
      endcase
    end
  end

  assign DATA_O1 = OEB1 ? '0 : rdata1;
  assign DATA_O2 = OEB2 ? '0 : rdata2;

endmodule

// File: tb/tb_cnn_mem_responder.sv
// Scoreboard bench for cnn_mem_responder: reset clear, latency, OEB gating, dual-port hazards, collisions.
module tb_cnn_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ADD1, ADD2;
  logic        CSB1, WEB1, OEB1, CSB2, WEB2, OEB2;
  logic [31:0] DATA_I1, DATA_I2, DATA_O1, DATA_O2;
  logic        mem_ready, wr_coll;

  cnn_mem_responder dut (
    .clk(clk), .rst(rst),
    .ADD1(ADD1), .CSB1(CSB1), .WEB1(WEB1), .OEB1(OEB1), .DATA_I1(DATA_I1), .DATA_O1(DATA_O1),
    .ADD2(ADD2), .CSB2(CSB2), .WEB2(WEB2), .OEB2(OEB2), .DATA_I2(DATA_I2), .DATA_O2(DATA_O2),
    .mem_ready(mem_ready), .wr_coll(wr_coll)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  logic [31:0] rd_m [2];
  bit          ready_m;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One access cycle on both ports; expectations come from the bench's own memory model.
  task automatic access(input string tag,
                        input bit c1, input bit w1, input logic [4:0] a1, input logic [31:0] d1,
                        input bit c2, input bit w2, input logic [4:0] a2, input logic [31:0] d2);
    bit   coll;
    exp_t e;
    CSB1 = c1; WEB1 = w1; ADD1 = a1; DATA_I1 = d1;
    CSB2 = c2; WEB2 = w2; ADD2 = a2; DATA_I2 = d2;
    coll = 1'b0;
    if (ready_m) begin
      if (!c1 && w1) begin rd_m[0] = model[a1]; sb.push_back('{1, model[a1], {tag, "_rd1"}}); end
      if (!c2 && w2) begin rd_m[1] = model[a2]; sb.push_back('{2, model[a2], {tag, "_rd2"}}); end
      coll = !c1 && !w1 && !c2 && !w2 && (a1 == a2);
      if (!c2 && !w2) model[a2] = d2;
      if (!c1 && !w1) model[a1] = d1;
    end
    cyc();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, (e.port == 1) ? DATA_O1 : DATA_O2, e.data);
    end
    check({tag, "_hold1"}, DATA_O1, OEB1 ? 32'h0 : rd_m[0]);
    check({tag, "_hold2"}, DATA_O2, OEB2 ? 32'h0 : rd_m[1]);
    check({tag, "_coll"}, {31'b0, wr_coll}, {31'b0, coll});
    CSB1 = 1'b1; WEB1 = 1'b1; CSB2 = 1'b1; WEB2 = 1'b1;
  endtask

  // Reset for ncyc cycles, then run through CLEAR while hammering both ports.
  task automatic do_reset(input int ncyc);
    int n;
    rst = 1'b1;
    repeat (ncyc) cyc();
    check("rst_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_coll", {31'b0, wr_coll}, 32'h0);
    check("rst_do1", DATA_O1, 32'h0);
    check("rst_do2", DATA_O2, 32'h0);
    rst = 1'b0;
    ready_m = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rd_m[0] = 32'h0;
    rd_m[1] = 32'h0;
    n = 0;
    while (!mem_ready && n < 100) begin
      access("clr", 1'b0, 1'b0, 5'd7, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd7, 32'h0);
      n++;
    end
    check("clear_len", n, 32);
    ready_m = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    ADD1 = '0; ADD2 = '0; DATA_I1 = '0; DATA_I2 = '0;
    CSB1 = 1'b1; WEB1 = 1'b1; OEB1 = 1'b0;
    CSB2 = 1'b1; WEB2 = 1'b1; OEB2 = 1'b0;
    ready_m = 1'b0;
    rd_m[0] = 32'h0;
    rd_m[1] = 32'h0;

    do_reset(2);

    // T1: preload, reset, the word is cleared and the clear-time write was ignored
    access("pre_wr", 1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd0, 32'h0);
    access("pre_rd", 1'b0, 1'b1, 5'd7, 32'h0, 1'b1, 1'b1, 5'd0, 32'h0);
    check("pre_val", DATA_O1, 32'hDEAD_BEEF);
    do_reset(1);
    access("t1_rd", 1'b0, 1'b1, 5'd7, 32'h0, 1'b1, 1'b1, 5'd0, 32'h0);
    check("t1_val", DATA_O1, 32'h0);

    // T2: write then read on port 1
    access("t2_wr", 1'b0, 1'b0, 5'd3, 32'h1234_5678, 1'b1, 1'b1, 5'd0, 32'h0);
    access("t2_rd", 1'b0, 1'b1, 5'd3, 32'h0, 1'b1, 1'b1, 5'd0, 32'h0);
    check("t2_val", DATA_O1, 32'h1234_5678);

    // T3: idle port holds rdata, OEB gates the output combinationally
    for (int i = 0; i < 4; i++) begin
      OEB1 = i[0];
      #2;
      check("t3_gate", DATA_O1, OEB1 ? 32'h0 : 32'h1234_5678);
    end
    OEB1 = 1'b0;
    access("t3_idle", 1'b1, 1'b1, 5'd3, 32'h0, 1'b1, 1'b1, 5'd0, 32'h0);

    // T4: cross-port read-during-write returns the old word
    access("t4_rdw", 1'b0, 1'b0, 5'd9, 32'hAAAA_0001, 1'b0, 1'b1, 5'd9, 32'h0);
    check("t4_old", DATA_O2, 32'h0);
    access("t4_rd", 1'b1, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 5'd9, 32'h0);
    check("t4_new", DATA_O2, 32'hAAAA_0001);

    // T5: write-write collision, port 1 wins, pulse lasts one cycle
    access("t5_ww", 1'b0, 1'b0, 5'd4, 32'h1, 1'b0, 1'b0, 5'd4, 32'h2);
    access("t5_rd", 1'b1, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 5'd4, 32'h0);
    check("t5_val", DATA_O2, 32'h1);

    // Same-port write leaves that port's rdata alone; different-address writes are independent
    access("sp_wr", 1'b0, 1'b0, 5'd20, 32'hCAFE_0020, 1'b0, 1'b0, 5'd21, 32'hCAFE_0021);
    access("sp_rd", 1'b0, 1'b1, 5'd21, 32'h0, 1'b0, 1'b1, 5'd20, 32'h0);

    // Random mixed traffic
    for (int i = 0; i < 40; i++) begin
      access("rnd", 1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom(),
                    1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom());
    end

    // T6: reset while READY drops mem_ready and wipes mem[0]
    access("t6_wr", 1'b0, 1'b0, 5'd0, 32'h55, 1'b1, 1'b1, 5'd0, 32'h0);
    access("t6_pre", 1'b0, 1'b1, 5'd0, 32'h0, 1'b1, 1'b1, 5'd0, 32'h0);
    do_reset(1);
    access("t6_rd", 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7, 32'h0);
    check("t6_val", DATA_O1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
